// File: rtl/arb_mux_4_1.sv
// rtl/arb_mux_4_1.sv - round-robin 4:1 arbiter feeding a single registered output word
// Optional per-requester saturating grant counters: define ARB_MUX_GRANT_CNT_EN.
module arb_mux_4_1 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready,
  output logic [31:0]        grant_cnt
);

  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             found;
  logic             can_load;
  logic             grant;
  logic [WIDTH-1:0] words [4];

  for (genvar g = 0; g < 4; g++) begin : g_words
    assign words[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Draining and refilling in the same cycle keeps throughput at one word per clock.
  assign can_load = !out_valid || out_ready;

  // Search ptr+1, ptr+2, ptr+3, ptr; the 2-bit add wraps, and k=4 lands back on ptr.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && in_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign grant    = can_load && found && !rst;
  assign in_ready = grant ? (4'b0001 << winner) : 4'b0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      ptr       <= 2'd3;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= words[winner];
      out_sel   <= winner;
      ptr       <= winner;
    end else if (can_load) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_MUX_GRANT_CNT_EN
  logic [7:0] cnt [4];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        cnt[i] <= 8'd0;
      end else if (in_ready[i] && in_valid[i] && cnt[i] != 8'hFF) begin
        cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  assign grant_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`else
  assign grant_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_arb_mux_4_1.sv
// tb/tb_arb_mux_4_1.sv - directed and randomized check of arb_mux_4_1 against a behavioural model
module tb_arb_mux_4_1;
  localparam int WIDTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         in_valid = 4'b0;
  logic [4*WIDTH-1:0] in_data = '0;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready = 1'b1;
  logic [31:0]        grant_cnt;

  arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: last-granted index plus the contents of the output register.
  int               m_ptr;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       m_sel;
  logic [7:0]       m_cnt [4];

  function automatic int model_winner();
    for (int k = 1; k <= 4; k++)
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    w = model_winner();
    if (rst || w < 0 || !(!m_valid || out_ready)) return 4'b0000;
    return 4'(1 << w);
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef ARB_MUX_GRANT_CNT_EN
    return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr   <= 3;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 2'd0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= 8'd0;
    end else if ((!m_valid || out_ready) && model_winner() >= 0) begin
      m_ptr   <= model_winner();
      m_valid <= 1'b1;
      m_data  <= in_data[model_winner()*WIDTH +: WIDTH];
      m_sel   <= 2'(model_winner());
      if (m_cnt[model_winner()] < 8'd255) m_cnt[model_winner()] <= m_cnt[model_winner()] + 8'd1;
    end else if (!m_valid || out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison plus the requester hold rule (pending words stay valid and stable).
  logic [3:0]         p_valid = 4'b0;
  logic [3:0]         p_ready = 4'b0;
  logic [4*WIDTH-1:0] p_data = '0;

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(exp_ready()));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    chk("grant_cnt", grant_cnt, exp_cnt());
    for (int i = 0; i < 4; i++)
      if (p_valid[i] && !p_ready[i])
        chk("req_hold", {27'd0, in_valid[i], in_data[i*WIDTH +: WIDTH]},
            {27'd0, 1'b1, p_data[i*WIDTH +: WIDTH]});
    p_valid <= in_valid;
    p_ready <= in_ready;
    p_data  <= in_data;
  end

  // Stimulus: requesters only change after being granted; everything else follows want_*.
  logic [3:0]       want_valid = 4'b0;
  logic [WIDTH-1:0] want_data [4];
  logic             want_rst = 1'b1;
  logic             want_ready = 1'b1;

  task automatic cycle();
    logic [3:0] rdy;
    @(negedge clk);
    rdy = in_ready;
    @(posedge clk);
    #1;
    rst = want_rst;
    out_ready = want_ready;
    for (int i = 0; i < 4; i++) begin
      if (!(in_valid[i] && !rdy[i])) begin
        in_valid[i] = want_valid[i];
        in_data[i*WIDTH +: WIDTH] = want_data[i];
      end
    end
    #2;
  endtask

  task automatic set_abcd();
    for (int i = 0; i < 4; i++) want_data[i] = WIDTH'(4'hA + i);
  endtask

  initial begin
    set_abcd();

    // Reset then idle
    cycle(); chk("rst_in_ready", 32'(in_ready), 0); chk("rst_out_valid", 32'(out_valid), 0);
    cycle(); chk("rst_grant_cnt", grant_cnt, 0);
    want_rst = 1'b0;
    cycle(); chk("idle_out_valid", 32'(out_valid), 0); chk("idle_in_ready", 32'(in_ready), 0);

    // Full contention: 0,1,2,3 repeating, out_sel/out_data one cycle behind
    want_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      cycle();
      chk("rr_in_ready", 32'(in_ready), 32'(1 << (n % 4)));
      if (n > 0) begin
        chk("rr_out_sel", 32'(out_sel), 32'((n - 1) % 4));
        chk("rr_out_data", 32'(out_data), 32'(4'hA + (n - 1) % 4));
      end
    end

    // Drain, leaving ptr at 2
    want_valid = 4'b0000;
    repeat (6) cycle();
    chk("drain_out_valid", 32'(out_valid), 0);

    // Backpressure
    want_valid = 4'b0101;
    cycle(); chk("bp_first", 32'(in_ready), 32'h1);
    want_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_data", 32'(out_data), 32'hA);
      chk("bp_out_sel", 32'(out_sel), 0);
    end
    want_ready = 1'b1;
    cycle(); chk("bp_release_req2", 32'(in_ready), 32'h4);
    cycle(); chk("bp_then_req0", 32'(in_ready), 32'h1); chk("bp_out_data_c", 32'(out_data), 32'hC);

    // Skip and wrap
    want_valid = 4'b0100;
    cycle(); chk("sw_req2", 32'(in_ready), 32'h4);
    want_valid = 4'b1001;
    cycle(); chk("sw_req3", 32'(in_ready), 32'h8);
    cycle(); chk("sw_req0", 32'(in_ready), 32'h1); chk("sw_sel3", 32'(out_sel), 3);

    // Single active requester
    want_valid = 4'b0010;
    repeat (3) cycle();
    repeat (5) begin
      cycle();
      chk("single_in_ready", 32'(in_ready), 32'h2);
      chk("single_out_sel", 32'(out_sel), 1);
      chk("single_out_valid", 32'(out_valid), 1);
    end

    // Mid-operation reset
    want_valid = 4'b1111;
    for (int i = 0; i < 4; i++) want_data[i] = WIDTH'(7);
    cycle();
    want_ready = 1'b0;
    cycle(); chk("mr_hold7", 32'(out_data), 32'h7); chk("mr_hold_valid", 32'(out_valid), 1);
    want_rst = 1'b1;
    cycle(); chk("mr_rst_in_ready", 32'(in_ready), 0);
    want_rst = 1'b0; want_ready = 1'b1;
    cycle(); chk("mr_out_valid", 32'(out_valid), 0); chk("mr_first_req0", 32'(in_ready), 32'h1);
    set_abcd();

    // Grant counter saturation on req1
    want_valid = 4'b0000;
    repeat (6) cycle();
    want_rst = 1'b1;
    cycle();
    want_rst = 1'b0; want_valid = 4'b0010;
    repeat (302) cycle();
`ifdef ARB_MUX_GRANT_CNT_EN
    chk("cnt_saturated", grant_cnt, 32'h0000_FF00);
`else
    chk("cnt_disabled", grant_cnt, 32'h0);
`endif

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      want_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) want_data[i] = WIDTH'($urandom);
      want_ready = ($urandom_range(0, 3) != 0);
      want_rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    want_rst = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
